// File: rtl/aurora_pkg.sv
// Shared Aurora lane definitions: AXI data width and the ordered-set codes
// produced by the lane decoder.
package aurora_pkg;
   localparam int AXI_DATA_SIZE = 32;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      SCP  = 2'd1,
      ECP  = 2'd2,
      I    = 2'd3
   } ordered_sets_e;
endpackage

// File: rtl/rx_data_controller_sat_counter.sv
// Saturating up-counter: increments on i_inc and holds once it reaches all-ones.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_cnt
);
   logic [CNT_W-1:0] r_cnt;

   // Count up until all-ones, then stick there
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      r_cnt <= '0;
      else if (i_inc && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
   end

   assign o_cnt = r_cnt;
endmodule

// File: rtl/rx_data_controller.sv
// Aurora receive framing controller. Strips SCP/ECP/I framing and rebuilds an
// AXI4-Stream frame. Because the last word is only known once ECP arrives,
// one data word is always held back until the next NONE or ECP decides its tlast.
module rx_data_controller
   import aurora_pkg::*;
#(
   parameter int DATA_W = AXI_DATA_SIZE,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              lane_up,
   input  ordered_sets_e     rx_ordered_sets,
   input  logic [DATA_W-1:0] rx_data,
   output logic              m_axi_valid,
   output logic              m_axi_last,
   output logic [DATA_W-1:0] m_axi_data,
   output logic              frame_err,
   output logic [CNT_W-1:0]  frame_cnt,
   output logic [CNT_W-1:0]  err_cnt
);
   typedef enum logic {IDLE, FRAME} state_e;

   state_e            r_state, w_state_nxt;
   logic [DATA_W-1:0] r_hold_data;
   logic              r_hold_valid;
   logic              r_valid, r_last, r_err;
   logic [DATA_W-1:0] r_data;
   logic [CNT_W-1:0]  r_frame_cnt;

   logic w_hold_ld, w_hold_clr, w_emit, w_last, w_err, w_frame_inc;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state and per-cycle actions; lane loss overrides ordered-set decode
   always_comb begin
      w_state_nxt = r_state;
      w_hold_ld   = 1'b0;
      w_hold_clr  = 1'b0;
      w_emit      = 1'b0;
      w_last      = 1'b0;
      w_err       = 1'b0;
      w_frame_inc = 1'b0;
      case (r_state)
         IDLE: begin
            if (lane_up) begin
               case (rx_ordered_sets)
                  SCP: begin
                     w_state_nxt = FRAME;
                     w_hold_clr  = 1'b1;
                  end
                  ECP:     w_err = 1'b1;
                  default: ;
               endcase
            end
         end
         FRAME: begin
            if (!lane_up) begin
               // Held word is dropped, never emitted
               w_err       = 1'b1;
               w_hold_clr  = 1'b1;
               w_state_nxt = IDLE;
            end else begin
               case (rx_ordered_sets)
                  NONE: begin
                     w_emit    = r_hold_valid;
                     w_hold_ld = 1'b1;
                  end
                  ECP: begin
                     if (r_hold_valid) begin
                        w_emit      = 1'b1;
                        w_last      = 1'b1;
                        w_frame_inc = 1'b1;
                     end else begin
                        w_err = 1'b1;
                     end
                     w_hold_clr  = 1'b1;
                     w_state_nxt = IDLE;
                  end
                  SCP: begin
                     // Missing ECP: close old frame without counting it, start anew
                     w_emit     = r_hold_valid;
                     w_last     = 1'b1;
                     w_err      = 1'b1;
                     w_hold_clr = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Hold-back register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold_data  <= '0;
         r_hold_valid <= 1'b0;
      end else if (w_hold_ld) begin
         r_hold_data  <= rx_data;
         r_hold_valid <= 1'b1;
      end else if (w_hold_clr) begin
         r_hold_data  <= '0;
         r_hold_valid <= 1'b0;
      end
   end

   // Registered AXI beat and error pulse, zero when idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_data  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_valid <= w_emit;
         r_last  <= w_emit & w_last;
         r_data  <= w_emit ? r_hold_data : '0;
         r_err   <= w_err;
      end
   end

   // Good-frame counter, wraps
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           r_frame_cnt <= '0;
      else if (w_frame_inc) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
   end

   sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .i_inc (w_err),
      .o_cnt (err_cnt)
   );

   assign m_axi_valid = r_valid;
   assign m_axi_last  = r_last;
   assign m_axi_data  = r_data;
   assign frame_err   = r_err;
   assign frame_cnt   = r_frame_cnt;
endmodule
